xsim_bus_arbiter: RTL and testbench

Round-robin arbiter and transfer sequencer for the XSim peripheral bus. Two requesters, instruction fetch and load/store, share one byte-wide bus to up to four memory-mapped peripherals (ROM, RAM, I/O). The block decodes the target device, drives the per-device select codes, address, write data and read/write direction, and returns the read byte with a one-cycle acknowledge. It is the only bus master; it never assigns the master select code to a device.

---
 rtl/xsim_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_xsim_bus_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/xsim_bus_arbiter.sv
// ---------------------------------------------------------------------------
// xsim_bus_arbiter: round-robin two-requester arbiter and byte-bus sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xsim_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DEV_SHIFT = 8,
  parameter int N_DEV     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_i,
  input  logic [ADDR_W-1:0]    addr0_i,
  input  logic [ADDR_W-1:0]    addr1_i,
  input  logic [1:0]           we_i,
  input  logic [7:0]           wdata0_i,
  input  logic [7:0]           wdata1_i,
  output logic [1:0]           ack_o,
  output logic                 err_o,
  output logic [7:0]           rdata_o,
  output logic [2*N_DEV-1:0]   bus_sel_o,
  output logic [DEV_SHIFT-1:0] bus_addr_o,
  output logic [7:0]           bus_wdata_o,
  output logic                 bus_rw_o,
  input  logic [7:0]           bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   winner, winner_nxt;
  logic   lat_we, lat_we_nxt;

  logic [1:0]           ack_nxt;
  logic                 err_nxt;
  logic [7:0]           rdata_nxt;
  logic [2*N_DEV-1:0]   sel_nxt;
  logic [DEV_SHIFT-1:0] addr_nxt;
  logic [7:0]           wdata_nxt;
  logic                 rw_nxt;

  logic              gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_we;
  logic [7:0]        gnt_wdata;
  logic [1:0]        gnt_dev;
  logic              gnt_unmapped;
  logic              unused_hi;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    gnt = (req_i == 2'b11) ? ~last : req_i[1];
  end

  assign gnt_addr     = gnt ? addr1_i : addr0_i;
  assign gnt_we       = we_i[gnt];
  assign gnt_wdata    = gnt ? wdata1_i : wdata0_i;
  assign gnt_dev      = gnt_addr[DEV_SHIFT+1:DEV_SHIFT];
  assign gnt_unmapped = ({1'b0, gnt_dev} >= 3'(N_DEV));
  assign unused_hi    = ^gnt_addr[ADDR_W-1:DEV_SHIFT+2];

  always_comb begin
    state_nxt  = state;
    last_nxt   = last;
    winner_nxt = winner;
    lat_we_nxt = lat_we;
    ack_nxt    = '0;
    err_nxt    = 1'b0;
    rdata_nxt  = rdata_o;
    sel_nxt    = '0;
    addr_nxt   = bus_addr_o;
    wdata_nxt  = bus_wdata_o;
    rw_nxt     = 1'b1;
    case (state)
      IDLE: begin
        if (|req_i) begin
          last_nxt   = gnt;
          winner_nxt = gnt;
          lat_we_nxt = gnt_we;
          if (gnt_unmapped) begin
            state_nxt    = ACK;
            ack_nxt[gnt] = 1'b1;
            err_nxt      = 1'b1;
            rdata_nxt    = 8'h00;
          end else begin
            state_nxt = ADDR;
            for (int d = 0; d < N_DEV; d++) begin
              if (gnt_dev == 2'(d)) sel_nxt[2*d +: 2] = 2'b01;
            end
            addr_nxt  = gnt_addr[DEV_SHIFT-1:0];
            wdata_nxt = gnt_wdata;
            rw_nxt    = ~gnt_we;
          end
        end
      end
      ADDR: begin
        if (lat_we) begin
          state_nxt       = ACK;
          ack_nxt[winner] = 1'b1;
          rdata_nxt       = 8'h00;
        end else begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        state_nxt       = ACK;
        ack_nxt[winner] = 1'b1;
        rdata_nxt       = bus_rdata_i;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;
      winner      <= 1'b0;
      lat_we      <= 1'b0;
      ack_o       <= '0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_rw_o    <= 1'b1;
    end else begin
      state       <= state_nxt;
      last        <= last_nxt;
      winner      <= winner_nxt;
      lat_we      <= lat_we_nxt;
      ack_o       <= ack_nxt;
      err_o       <= err_nxt;
      rdata_o     <= rdata_nxt;
      bus_sel_o   <= sel_nxt;
      bus_addr_o  <= addr_nxt;
      bus_wdata_o <= wdata_nxt;
      bus_rw_o    <= rw_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xsim_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xsim_bus_arbiter: directed bench with ack scoreboard and a memory device model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_xsim_bus_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DEV_SHIFT = 8;
  localparam int N_DEV     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]           req_i;
  logic [ADDR_W-1:0]    addr0_i, addr1_i;
  logic [1:0]           we_i;
  logic [7:0]           wdata0_i, wdata1_i;
  logic [1:0]           ack_o;
  logic                 err_o;
  logic [7:0]           rdata_o;
  logic [2*N_DEV-1:0]   bus_sel_o;
  logic [DEV_SHIFT-1:0] bus_addr_o;
  logic [7:0]           bus_wdata_o;
  logic                 bus_rw_o;
  logic [7:0]           bus_rdata_i = 8'h00;

  xsim_bus_arbiter #(.ADDR_W(ADDR_W), .DEV_SHIFT(DEV_SHIFT), .N_DEV(N_DEV)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr0_i(addr0_i), .addr1_i(addr1_i),
    .we_i(we_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .ack_o(ack_o),
    .err_o(err_o), .rdata_o(rdata_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rw_o(bus_rw_o), .bus_rdata_i(bus_rdata_i)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  logic [10:0] sb_q[$];

  // Device model: samples select/address at the end of ADDR, drives read data in DATA.
  logic [7:0] mem [0:N_DEV-1][0:255];
  logic mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int d = 0; d < N_DEV; d++)
        for (int a = 0; a < 256; a++)
          mem[d][a] <= 8'(a) ^ 8'(d << 6);
      mem[0][8'h04] <= 8'hA5;
      mem[1][8'h10] <= 8'h5A;
      mem_ready <= 1'b1;
    end else begin
      for (int d = 0; d < N_DEV; d++) begin
        if (bus_sel_o[2*d +: 2] == 2'b01) begin
          if (bus_rw_o) bus_rdata_i <= mem[d][bus_addr_o];
          else          mem[d][bus_addr_o] <= bus_wdata_o;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [10:0] e;
    n_cmp++;
    assert (sb_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s: observed ack with empty scoreboard, ack=%b", tag, ack_o);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk(tag, {21'b0, ack_o, err_o, rdata_o}, {21'b0, e});
    end
  endtask

  task automatic wait_ack(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_o == 2'b00 && n < budget);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},   ack_o, 2'b00);
    chk({tag, "_err"},   err_o, 1'b0);
    chk({tag, "_rdata"}, rdata_o, 8'h00);
    chk({tag, "_sel"},   bus_sel_o, 6'b0);
    chk({tag, "_addr"},  bus_addr_o, 8'h00);
    chk({tag, "_wdata"}, bus_wdata_o, 8'h00);
    chk({tag, "_rw"},    bus_rw_o, 1'b1);
  endtask

  // Bus invariants: selects only 00/01 with at most one active, ack one-hot or zero.
  always @(negedge clk) begin
    int nz;
    logic bad_code;
    if (mon_en) begin
      nz = 0;
      bad_code = 1'b0;
      for (int d = 0; d < N_DEV; d++) begin
        if (bus_sel_o[2*d +: 2] != 2'b00) nz++;
        if (bus_sel_o[2*d +: 2] > 2'b01) bad_code = 1'b1;
      end
      chk("mon_sel_count", (nz > 1) ? 32'd1 : 32'd0, 32'd0);
      chk("mon_sel_code", bad_code, 1'b0);
      chk("mon_ack_onehot", (ack_o == 2'b11) ? 32'd1 : 32'd0, 32'd0);
    end
  end

  initial begin
    int n;
    req_i = 2'b00; addr0_i = '0; addr1_i = '0; we_i = 2'b00;
    wdata0_i = 8'h00; wdata1_i = 8'h00;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Read ROM byte 4.
    addr0_i = 32'h0000_0004; we_i = 2'b00; req_i = 2'b01;
    sb_q.push_back({2'b01, 1'b0, 8'hA5});
    @(negedge clk);
    chk("rd_c1_sel", bus_sel_o, 6'b000001);
    chk("rd_c1_addr", bus_addr_o, 8'h04);
    chk("rd_c1_rw", bus_rw_o, 1'b1);
    chk("rd_c1_ack", ack_o, 2'b00);
    @(negedge clk);
    chk("rd_c2_sel", bus_sel_o, 6'b0);
    chk("rd_c2_rw", bus_rw_o, 1'b1);
    chk("rd_c2_ack", ack_o, 2'b00);
    @(negedge clk);
    sb_check("rd_c3_ack");
    req_i[0] = 1'b0;
    @(negedge clk);
    chk("rd_c4_ack", ack_o, 2'b00);

    // Write 0x3C to device 1, offset 0x23.
    addr1_i = 32'h0000_0123; wdata1_i = 8'h3C; we_i = 2'b10; req_i = 2'b10;
    sb_q.push_back({2'b10, 1'b0, 8'h00});
    @(negedge clk);
    chk("wr_c1_sel", bus_sel_o, 6'b000100);
    chk("wr_c1_addr", bus_addr_o, 8'h23);
    chk("wr_c1_rw", bus_rw_o, 1'b0);
    chk("wr_c1_wdata", bus_wdata_o, 8'h3C);
    chk("wr_c1_ack", ack_o, 2'b00);
    @(negedge clk);
    sb_check("wr_c2_ack");
    chk("wr_c2_sel", bus_sel_o, 6'b0);
    req_i[1] = 1'b0; we_i = 2'b00;
    @(negedge clk);
    chk("wr_mem", mem[1][8'h23], 8'h3C);

    // Unmapped device 3.
    addr0_i = 32'h0000_0300; req_i = 2'b01;
    sb_q.push_back({2'b01, 1'b1, 8'h00});
    @(negedge clk);
    chk("err_c1_sel", bus_sel_o, 6'b0);
    sb_check("err_c1_ack");
    req_i = 2'b00;
    @(negedge clk);
    chk("err_c2_ack", ack_o, 2'b00);
    chk("err_c2_err", err_o, 1'b0);

    // Reset during DATA of a read by requester 1.
    addr1_i = 32'h0000_0110; req_i = 2'b10;
    @(negedge clk);
    chk("rst_mid_c1_sel", bus_sel_o, 6'b000100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    rst = 1'b0;

    // Continuous contention from reset: grants 0,1,0,1.
    addr0_i = 32'h0000_0004; addr1_i = 32'h0000_0110; we_i = 2'b00; req_i = 2'b11;
    sb_q.push_back({2'b01, 1'b0, 8'hA5});
    sb_q.push_back({2'b10, 1'b0, 8'h5A});
    sb_q.push_back({2'b01, 1'b0, 8'hA5});
    sb_q.push_back({2'b10, 1'b0, 8'h5A});
    for (int i = 0; i < 4; i++) begin
      wait_ack(8, n);
      chk($sformatf("rr_gap%0d", i), n, (i == 0) ? 32'd3 : 32'd4);
      sb_check($sformatf("rr_ack%0d", i));
    end
    req_i = 2'b00;
    @(negedge clk);

    // Inputs change during ADDR; latched address must be used.
    addr0_i = 32'h0000_0004; req_i = 2'b01;
    sb_q.push_back({2'b01, 1'b0, 8'hA5});
    @(negedge clk);
    chk("chg_c1_addr", bus_addr_o, 8'h04);
    addr0_i = 32'h0000_0110; req_i = 2'b00;
    wait_ack(6, n);
    chk("chg_gap", n, 32'd2);
    sb_check("chg_ack");
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
